if_stage_resp: RTL and testbench
================================

// Module: if_stage_resp
// PURPOSE
// - Fetch-side receiver of instruction-memory responses; opposite end of the fetch request path.
// - Pairs each returned word with the address of the request that produced it.
// - Buffers {addr, rdata, err} in order and presents them to decode over a valid/ready handshake.
// - Tracks outstanding requests, throttles new ones (req_allowed_o), discards stale responses after a flush.
// PARAMETERS
// - DEPTH            2   response FIFO entries (>=1)
// - MAX_OUTSTANDING  2   max requests in flight to memory (>=1)
// PORTS
// - clk_i            in   1   clock; single clock domain
// - rst_ni           in   1   reset, asynchronous, active-low
// - req_issued_i     in   1   1-cycle pulse: fetch request accepted by memory
// - req_addr_i       in   32  address of that request (valid with req_issued_i)
// - req_allowed_o    out  1   fetch may issue a request this cycle
// - instr_rvalid_i   in   1   memory response valid (1 cycle per response)
// - instr_rdata_i    in   32  response data
// - instr_err_i      in   1   response bus error
// - flush_i          in   1   PC redirect: drop buffered and in-flight instructions
// - instr_valid_o    out  1   decode-side entry valid
// - instr_ready_i    in   1   decode accepts entry
// - instr_addr_o     out  32  address of head entry
// - instr_rdata_o    out  32  data of head entry
// - instr_err_o      out  1   error flag of head entry
// - spurious_o       out  1   1-cycle pulse: rvalid with nothing outstanding
// BEHAVIOUR
// - Reset: FIFO empty, addr queue empty, outst_q=0, discard_q=0.
//   Outputs: instr_valid_o=0, addr/rdata=0, err=0, spurious_o=0, req_allowed_o=1.
// - Addr queue (MAX_OUTSTANDING deep)
//   - push req_addr_i on req_issued_i.
//   - pop on every instr_rvalid_i when discard_q==0.
// - outst_q, width $clog2(MAX_OUTSTANDING+1): +1 on req_issued_i, -1 on counted rvalid; both same cycle -> unchanged.
// - discard_q: while nonzero, each rvalid decrements it and decrements outst_q. Data is dropped, addr queue not popped.
// - Push {queue head addr, rdata, err} into FIFO on rvalid when discard_q==0.
//   Latency: rvalid in cycle N -> instr_valid_o=1 in N+1 (registered, no bypass).
// - Head outputs come straight from FIFO head. Pop when instr_valid_o && instr_ready_i.
//   Push and pop in the same cycle is legal, including when the FIFO is full.
// - req_allowed_o = (outst_q + fifo_count) < DEPTH && outst_q < MAX_OUTSTANDING.
//   Guarantees a slot for every response, so no push is ever lost.
// - flush_i (registered effect next cycle)
//   - FIFO and addr queue cleared.
//   - discard_q <= outst_q (minus 1 if rvalid this cycle).
//   - instr_valid_o forced 0 during the flush cycle; a ready in that cycle pops nothing.
//   - A req_issued_i in the flush cycle is the new PC: it is kept. Addr pushed after clear, outst_q counts it, not discarded.
//   - A rvalid in the flush cycle is discarded.
// - Spurious: rvalid with outst_q==0 -> spurious_o=1 next cycle; response ignored, counters unchanged.
// - Wrap-around: FIFO and queue pointers wrap modulo depth; non-power-of-2 depths supported.
// - Reset mid-operation: all state cleared immediately (async); in-flight responses after reset are spurious.
// STRUCTURE
// - Package if_pkg: fetch_entry_t struct {logic [31:0] addr; logic [31:0] rdata; logic err;}
//   and ADDR_W=32, DATA_W=32.
// - Sub-module fetch_fifo #(DEPTH, type T): flush input, full/empty/count outputs.
//   Instantiated twice: response FIFO (T=fetch_entry_t) and addr queue (T=logic[31:0]).
// - Top holds outst_q, discard_q, spurious logic, req_allowed_o.
// TESTING
// - Basic: issue 0x100, rvalid rdata=0x00000013 next cycle
//   -> valid=1 one cycle later, addr=0x100, rdata=0x13, err=0.
// - Order/backpressure: issue 0x100,0x104, ready=0, two responses
//   -> req_allowed_o=0; entries 0x100 then 0x104 on ready=1.
// - Flush in flight: issue 0x200,0x204, flush_i before responses, same cycle issue 0x300
//   -> two responses dropped; third presented as 0x300.
// - Full FIFO push+pop: DEPTH=2 full, ready=1 with rvalid the same cycle
//   -> no loss, count stays 2, order preserved.
// - Error/spurious: rvalid err=1 for 0x400 -> instr_err_o=1 at addr 0x400;
//   rvalid with none outstanding -> spurious_o pulse, no valid.
// - Reset mid-op: rst_ni low with 2 outstanding and 1 buffered
//   -> valid=0, req_allowed_o=1 immediately; late rvalid -> spurious_o.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and widths for the fetch response path.
//   ADDR_W / DATA_W : fetch address and instruction word widths
//   fetch_entry_t   : one buffered response {addr, rdata, err} handed to decode
package if_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order FIFO with synchronous clear, used both for buffered
// responses and for the queue of in-flight request addresses.
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush          : clear contents; a push in the same cycle lands after the clear
//   push/push_data : write one entry
//   pop            : remove head entry (ignored when empty or flushing)
//   head           : current head entry
//   full/empty     : occupancy flags
//   count          : number of stored entries
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type T = logic [31:0],
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_base;
  logic [PW-1:0] rd_base;
  logic [CW-1:0] cnt_base;
  logic          do_push;
  logic          do_pop;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rd_ptr];

  // A flush acts as an empty FIFO for this cycle's push.
  assign wr_base  = flush ? '0 : wr_ptr;
  assign rd_base  = flush ? '0 : rd_ptr;
  assign cnt_base = flush ? '0 : count;
  assign do_pop   = pop && !empty && !flush;
  assign do_push  = push && (flush || !full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_base] <= push_data;
      end
      wr_ptr <= do_push ? nxt(wr_base) : wr_base;
      rd_ptr <= do_pop ? nxt(rd_ptr) : rd_base;
      count  <= cnt_base + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/if_stage_resp.sv
// Fetch-side receiver of instruction-memory responses. Pairs each returned
// word with the address of its request, buffers entries in order for decode,
// throttles new requests and drops responses that belong to a flushed stream.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   req_issued_i/addr_i  : request accepted by memory, and its address
//   req_allowed_o        : fetch may issue a request this cycle
//   instr_rvalid_i/rdata_i/err_i : memory response
//   flush_i              : PC redirect, drop buffered and in-flight instructions
//   instr_valid_o/ready_i, instr_addr_o/rdata_o/err_o : decode-side head entry
//   spurious_o           : pulse after a response arrived with nothing outstanding
module if_stage_resp
  import if_pkg::*;
#(
  parameter int unsigned DEPTH           = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_issued_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              req_allowed_o,
  input  logic              instr_rvalid_i,
  input  logic [DATA_W-1:0] instr_rdata_i,
  input  logic              instr_err_i,
  input  logic              flush_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [ADDR_W-1:0] instr_addr_o,
  output logic [DATA_W-1:0] instr_rdata_o,
  output logic              instr_err_o,
  output logic              spurious_o
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [OW-1:0]     outst_q;
  logic [OW-1:0]     discard_q;
  logic              spurious_q;

  logic              rv_counted;
  logic              rv_spurious;
  logic              rv_accept;

  fetch_entry_t      rf_in;
  fetch_entry_t      rf_head;
  logic              rf_pop;
  logic              rf_full;
  logic              rf_empty;
  logic [CW-1:0]     rf_count;

  logic [ADDR_W-1:0] aq_head;
  logic              aq_full;
  logic              aq_empty;
  logic [OW-1:0]     aq_count;

  logic              unused_ok;

  // outst_q counts every in-flight request, including ones to be discarded,
  // so a response with outst_q==0 cannot belong to any request.
  assign rv_counted  = instr_rvalid_i && (outst_q != '0);
  assign rv_spurious = instr_rvalid_i && (outst_q == '0);
  assign rv_accept   = rv_counted && (discard_q == '0) && !flush_i && !aq_empty;

  always_comb begin
    rf_in       = '0;
    rf_in.addr  = aq_head;
    rf_in.rdata = instr_rdata_i;
    rf_in.err   = instr_err_i;
  end

  fetch_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .T     (logic [ADDR_W-1:0])
  ) u_addr_q (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .flush     (flush_i),
    .push      (req_issued_i),
    .push_data (req_addr_i),
    .pop       (rv_accept),
    .head      (aq_head),
    .full      (aq_full),
    .empty     (aq_empty),
    .count     (aq_count)
  );

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_resp_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .flush     (flush_i),
    .push      (rv_accept),
    .push_data (rf_in),
    .pop       (rf_pop),
    .head      (rf_head),
    .full      (rf_full),
    .empty     (rf_empty),
    .count     (rf_count)
  );

  assign instr_valid_o = !rf_empty && !flush_i;
  assign rf_pop        = instr_valid_o && instr_ready_i;
  assign instr_addr_o  = rf_head.addr;
  assign instr_rdata_o = rf_head.rdata;
  assign instr_err_o   = rf_head.err;
  assign spurious_o    = spurious_q;

  // Reserving a FIFO slot per outstanding request means a response push
  // never meets a full FIFO without a pop in the same cycle.
  assign req_allowed_o = ((32'(outst_q) + 32'(rf_count)) < DEPTH) &&
                         (32'(outst_q) < MAX_OUTSTANDING) && !aq_full;

  assign unused_ok = ^{rf_full, aq_count};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outst_q    <= '0;
      discard_q  <= '0;
      spurious_q <= 1'b0;
    end else begin
      outst_q    <= outst_q + OW'(req_issued_i) - OW'(rv_counted);
      spurious_q <= rv_spurious;
      // Everything in flight at the redirect is stale; a request issued in
      // the flush cycle is not part of outst_q yet and so stays live.
      if (flush_i) begin
        discard_q <= outst_q - OW'(rv_counted);
      end else if (rv_counted && (discard_q != '0)) begin
        discard_q <= discard_q - OW'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_stage_resp.sv
module tb_if_stage_resp;

  localparam int DEPTH = 2;
  localparam int MAXO  = 2;

  logic        clk;
  logic        rst_n;
  logic        req_issued;
  logic [31:0] req_addr;
  logic        req_allowed;
  logic        rvalid;
  logic [31:0] rdata;
  logic        rerr;
  logic        flush;
  logic        ivalid;
  logic        iready;
  logic [31:0] iaddr;
  logic [31:0] irdata;
  logic        ierr;
  logic        spurious;

  if_stage_resp #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_issued_i   (req_issued),
    .req_addr_i     (req_addr),
    .req_allowed_o  (req_allowed),
    .instr_rvalid_i (rvalid),
    .instr_rdata_i  (rdata),
    .instr_err_i    (rerr),
    .flush_i        (flush),
    .instr_valid_o  (ivalid),
    .instr_ready_i  (iready),
    .instr_addr_o   (iaddr),
    .instr_rdata_o  (irdata),
    .instr_err_o    (ierr),
    .spurious_o     (spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          iss;
    logic [31:0] a;
    bit          rv;
    logic [31:0] d;
    bit          e;
    bit          fl;
    bit          rdy;
    bit          ev;
    logic [31:0] ea;
    logic [31:0] ed;
    bit          ee;
    bit          eal;
    bit          esp;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        e;
  } ent_t;

  vec_t        vt[$];
  ent_t        mq[$];
  logic [31:0] maq[$];
  int          mout;
  int          mdisc;
  bit          mspur;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input bit iss, input logic [31:0] a, input bit rv, input logic [31:0] d,
                     input bit e, input bit fl, input bit rdy);
    req_issued = iss;
    req_addr   = a;
    rvalid     = rv;
    rdata      = d;
    rerr       = e;
    flush      = fl;
    iready     = rdy;
  endtask

  function automatic vec_t mk(bit iss, logic [31:0] a, bit rv, logic [31:0] d, bit e, bit fl,
                              bit rdy, bit ev, logic [31:0] ea, logic [31:0] ed, bit ee,
                              bit eal, bit esp);
    vec_t v;
    v.iss = iss; v.a = a; v.rv = rv; v.d = d; v.e = e; v.fl = fl; v.rdy = rdy;
    v.ev = ev; v.ea = ea; v.ed = ed; v.ee = ee; v.eal = eal; v.esp = esp;
    return v;
  endfunction

  initial begin
    ent_t ent;
    bit   iss, rv, e, fl, rdy, ev, eal, pop, counted;
    logic [31:0] a, d;

    drv(0, '0, 0, '0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset valid", 32'(ivalid), 0);
    chk("reset allowed", 32'(req_allowed), 1);
    chk("reset spurious", 32'(spurious), 0);
    chk("reset addr", iaddr, 0);
    chk("reset rdata", irdata, 0);
    chk("reset err", 32'(ierr), 0);
    @(negedge clk);
    rst_n = 1'b1;

    //            iss a          rv d          e fl rdy  ev ea         ed          ee al sp
    // basic
    vt.push_back(mk(1, 32'h100, 0, 0,          0, 0, 0,  0, 0,         0,          0, 1, 0));
    vt.push_back(mk(0, 0,       1, 32'h13,     0, 0, 0,  0, 0,         0,          0, 1, 0));
    vt.push_back(mk(0, 0,       0, 0,          0, 0, 0,  1, 32'h100,   32'h13,     0, 1, 0));
    vt.push_back(mk(0, 0,       0, 0,          0, 0, 1,  1, 32'h100,   32'h13,     0, 1, 0));
    vt.push_back(mk(0, 0,       0, 0,          0, 0, 0,  0, 0,         0,          0, 1, 0));
    // order and backpressure
    vt.push_back(mk(1, 32'h100, 0, 0,          0, 0, 0,  0, 0,         0,          0, 1, 0));
    vt.push_back(mk(1, 32'h104, 0, 0,          0, 0, 0,  0, 0,         0,          0, 1, 0));
    vt.push_back(mk(0, 0,       1, 32'hA,      0, 0, 0,  0, 0,         0,          0, 0, 0));
    vt.push_back(mk(0, 0,       1, 32'hB,      0, 0, 0,  1, 32'h100,   32'hA,      0, 0, 0));
    vt.push_back(mk(0, 0,       0, 0,          0, 0, 0,  1, 32'h100,   32'hA,      0, 0, 0));
    vt.push_back(mk(0, 0,       0, 0,          0, 0, 1,  1, 32'h100,   32'hA,      0, 0, 0));
    vt.push_back(mk(0, 0,       0, 0,          0, 0, 1,  1, 32'h104,   32'hB,      0, 1, 0));
    vt.push_back(mk(0, 0,       0, 0,          0, 0, 0,  0, 0,         0,          0, 1, 0));
    // flush with requests in flight, new PC issued in the flush cycle
    vt.push_back(mk(1, 32'h200, 0, 0,          0, 0, 0,  0, 0,         0,          0, 1, 0));
    vt.push_back(mk(1, 32'h204, 0, 0,          0, 0, 0,  0, 0,         0,          0, 1, 0));
    vt.push_back(mk(1, 32'h300, 0, 0,          0, 1, 1,  0, 0,         0,          0, 0, 0));
    vt.push_back(mk(0, 0,       1, 32'hDEAD1,  0, 0, 1,  0, 0,         0,          0, 0, 0));
    vt.push_back(mk(0, 0,       1, 32'hDEAD2,  0, 0, 1,  0, 0,         0,          0, 0, 0));
    vt.push_back(mk(0, 0,       1, 32'h33,     0, 0, 1,  0, 0,         0,          0, 1, 0));
    vt.push_back(mk(0, 0,       0, 0,          0, 0, 1,  1, 32'h300,   32'h33,     0, 1, 0));
    vt.push_back(mk(0, 0,       0, 0,          0, 0, 0,  0, 0,         0,          0, 1, 0));
    // full FIFO with simultaneous push and pop
    vt.push_back(mk(1, 32'h500, 0, 0,          0, 0, 0,  0, 0,         0,          0, 1, 0));
    vt.push_back(mk(1, 32'h504, 0, 0,          0, 0, 0,  0, 0,         0,          0, 1, 0));
    vt.push_back(mk(0, 0,       1, 32'h1,      0, 0, 0,  0, 0,         0,          0, 0, 0));
    vt.push_back(mk(1, 32'h508, 1, 32'h2,      0, 0, 0,  1, 32'h500,   32'h1,      0, 0, 0));
    vt.push_back(mk(0, 0,       1, 32'h3,      0, 0, 1,  1, 32'h500,   32'h1,      0, 0, 0));
    vt.push_back(mk(0, 0,       0, 0,          0, 0, 1,  1, 32'h504,   32'h2,      0, 0, 0));
    vt.push_back(mk(0, 0,       0, 0,          0, 0, 1,  1, 32'h508,   32'h3,      0, 1, 0));
    vt.push_back(mk(0, 0,       0, 0,          0, 0, 0,  0, 0,         0,          0, 1, 0));
    // error response, then spurious response
    vt.push_back(mk(1, 32'h400, 0, 0,          0, 0, 0,  0, 0,         0,          0, 1, 0));
    vt.push_back(mk(0, 0,       1, 32'h77,     1, 0, 0,  0, 0,         0,          0, 1, 0));
    vt.push_back(mk(0, 0,       0, 0,          0, 0, 1,  1, 32'h400,   32'h77,     1, 1, 0));
    vt.push_back(mk(0, 0,       1, 32'h99,     0, 0, 0,  0, 0,         0,          0, 1, 0));
    vt.push_back(mk(0, 0,       0, 0,          0, 0, 0,  0, 0,         0,          0, 1, 1));
    vt.push_back(mk(0, 0,       0, 0,          0, 0, 0,  0, 0,         0,          0, 1, 0));

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      drv(vt[i].iss, vt[i].a, vt[i].rv, vt[i].d, vt[i].e, vt[i].fl, vt[i].rdy);
      #1;
      chk($sformatf("row%0d valid", i), 32'(ivalid), 32'(vt[i].ev));
      chk($sformatf("row%0d allowed", i), 32'(req_allowed), 32'(vt[i].eal));
      chk($sformatf("row%0d spurious", i), 32'(spurious), 32'(vt[i].esp));
      if (vt[i].ev) begin
        chk($sformatf("row%0d addr", i), iaddr, vt[i].ea);
        chk($sformatf("row%0d rdata", i), irdata, vt[i].ed);
        chk($sformatf("row%0d err", i), 32'(ierr), 32'(vt[i].ee));
      end
    end

    // reset with two outstanding and one buffered entry
    @(negedge clk); drv(1, 32'h600, 0, 0, 0, 0, 0);
    @(negedge clk); drv(0, 0, 1, 32'h60, 0, 0, 0);
    @(negedge clk); drv(1, 32'h604, 0, 0, 0, 0, 0);
    @(negedge clk); drv(1, 32'h608, 0, 0, 0, 0, 0);
    @(negedge clk); drv(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("pre-reset valid", 32'(ivalid), 1);
    chk("pre-reset allowed", 32'(req_allowed), 0);
    rst_n = 1'b0;
    #1;
    chk("async reset valid", 32'(ivalid), 0);
    chk("async reset allowed", 32'(req_allowed), 1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); drv(0, 0, 1, 32'hBAD, 0, 0, 1);
    #1;
    chk("late rvalid valid", 32'(ivalid), 0);
    @(negedge clk); drv(0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("late rvalid spurious", 32'(spurious), 1);
    chk("late rvalid no valid", 32'(ivalid), 0);
    @(negedge clk);
    #1;
    chk("spurious one cycle", 32'(spurious), 0);

    // randomized traffic against a queue-level model
    mq.delete(); maq.delete(); mout = 0; mdisc = 0; mspur = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      eal = ((mout + mq.size()) < DEPTH) && (mout < MAXO);
      iss = eal && ($urandom_range(1, 0) == 1);
      a   = {$urandom_range(32'hFFFF, 0), 2'b00};
      rv  = (mout > 0) ? ($urandom_range(1, 0) == 1) : ($urandom_range(19, 0) == 0);
      d   = $urandom;
      e   = ($urandom_range(7, 0) == 0);
      fl  = ($urandom_range(31, 0) == 0);
      rdy = ($urandom_range(3, 0) != 0);
      drv(iss, a, rv, d, e, fl, rdy);
      #1;
      ev = (mq.size() > 0) && !fl;
      chk($sformatf("rnd%0d valid", c), 32'(ivalid), 32'(ev));
      chk($sformatf("rnd%0d allowed", c), 32'(req_allowed), 32'(eal));
      chk($sformatf("rnd%0d spurious", c), 32'(spurious), 32'(mspur));
      if (ev) begin
        chk($sformatf("rnd%0d addr", c), iaddr, mq[0].a);
        chk($sformatf("rnd%0d rdata", c), irdata, mq[0].d);
        chk($sformatf("rnd%0d err", c), 32'(ierr), 32'(mq[0].e));
      end
      pop     = ev && rdy;
      counted = rv && (mout > 0);
      mspur   = rv && (mout == 0);
      if (fl) begin
        mq.delete();
        maq.delete();
        mdisc = mout - int'(counted);
      end else begin
        if (pop) void'(mq.pop_front());
        if (counted) begin
          if (mdisc > 0) begin
            mdisc--;
          end else begin
            ent.a = maq.pop_front();
            ent.d = d;
            ent.e = e;
            mq.push_back(ent);
          end
        end
      end
      if (iss) maq.push_back(a);
      mout = mout + int'(iss) - int'(counted);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
